// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: single-beat reads/writes with WAIT_STATES read latency.
// Optional per-word even parity storage and checking is enabled by defining DM_PARITY_EN.
module dm_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    input  logic              parity_inj,
    output logic              parity_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam bit         NO_WAIT  = (WAIT_STATES == 0);
    localparam logic [2:0] CNT_LOAD = NO_WAIT ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t              state, next_state;
    logic [2:0]          cnt, cnt_next;
    logic [ADDR_W-1:0]   raddr;
    logic [ADDR_W-1:0]   rd_sel;
    logic                accept;
    logic                load_resp;
    logic                perr_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign stall       = (state == WAIT);
    assign rdata_valid = (state == RESP);
    assign accept      = mem_en && !stall;
    assign load_resp   = (next_state == RESP);
    // With no wait states the response is captured at the accept edge, so read straight from addr.
    assign rd_sel      = (state == WAIT) ? raddr : addr;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept && !mem_rw) begin
                    if (NO_WAIT) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            raddr <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (accept && !mem_rw) begin
                raddr <= addr;
            end
        end
    end

    // Array contents are deliberately not reset so data survives a pipeline reset.
    always_ff @(posedge clk) begin
        if (accept && mem_rw) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (load_resp) begin
            rdata <= mem[rd_sel];
        end
    end

`ifdef DM_PARITY_EN
    logic par [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (accept && mem_rw) begin
            par[addr] <= (^wdata) ^ parity_inj;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q <= 1'b0;
        end else if (load_resp) begin
            perr_q <= (^mem[rd_sel]) != par[rd_sel];
        end
    end
`else
    logic unused_inj;
    assign unused_inj = parity_inj;
    assign perr_q     = 1'b0;
`endif

    assign parity_err = rdata_valid && perr_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with WAIT_STATES=0 and one with WAIT_STATES=2.
module tb_dm_responder;

    logic       clk = 1'b0;
    logic       reset;

    logic       en0, rw0, inj0;
    logic [7:0] addr0, wdata0;
    logic [7:0] rdata0;
    logic       valid0, stall0, perr0;

    logic       en2, rw2, inj2;
    logic [7:0] addr2, wdata2;
    logic [7:0] rdata2;
    logic       valid2, stall2, perr2;

    int checks = 0;
    int errors = 0;

    logic exp_perr;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_en(en0), .mem_rw(rw0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .rdata_valid(valid0), .stall(stall0),
        .parity_inj(inj0), .parity_err(perr0)
    );

    dm_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .mem_en(en2), .mem_rw(rw2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .rdata_valid(valid2), .stall(stall2),
        .parity_inj(inj2), .parity_err(perr2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic en, input logic rw, input logic [7:0] a,
                        input logic [7:0] d, input logic inj);
        en0 = en; rw0 = rw; addr0 = a; wdata0 = d; inj0 = inj;
    endtask

    task automatic req2(input logic en, input logic rw, input logic [7:0] a,
                        input logic [7:0] d, input logic inj);
        en2 = en; rw2 = rw; addr2 = a; wdata2 = d; inj2 = inj;
    endtask

    // Full WAIT_STATES=2 read: two stall cycles, then a single valid cycle.
    task automatic read2(input string tag, input logic [7:0] a, input logic [7:0] exp);
        req2(1'b1, 1'b0, a, 8'h00, 1'b0);
        tick();
        req2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk({tag, "_stall1"}, {7'd0, stall2}, 8'd1);
        chk({tag, "_nv1"}, {7'd0, valid2}, 8'd0);
        tick();
        chk({tag, "_stall2"}, {7'd0, stall2}, 8'd1);
        chk({tag, "_nv2"}, {7'd0, valid2}, 8'd0);
        tick();
        chk({tag, "_valid"}, {7'd0, valid2}, 8'd1);
        chk({tag, "_rdata"}, rdata2, exp);
        chk({tag, "_nostall"}, {7'd0, stall2}, 8'd0);
        tick();
        chk({tag, "_vdrop"}, {7'd0, valid2}, 8'd0);
    endtask

    initial begin
`ifdef DM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        reset = 1'b0;
        req0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        req2(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);

        // Reset held with a read request pending: outputs stay at reset values.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdata0", rdata0, 8'h00);
            chk("rst_valid0", {7'd0, valid0}, 8'd0);
            chk("rst_stall0", {7'd0, stall0}, 8'd0);
            chk("rst_stall2", {7'd0, stall2}, 8'd0);
        end
        req0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        req2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        chk("idle_valid0", {7'd0, valid0}, 8'd0);
        chk("idle_perr0", {7'd0, perr0}, 8'd0);

        // WAIT_STATES=0: write then read on the next cycle.
        req0(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0);
        tick();
        chk("w_valid0", {7'd0, valid0}, 8'd0);
        chk("w_stall0", {7'd0, stall0}, 8'd0);
        req0(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        tick();
        chk("r10_valid0", {7'd0, valid0}, 8'd1);
        chk("r10_rdata0", rdata0, 8'h5A);
        chk("r10_stall0", {7'd0, stall0}, 8'd0);
        req0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("r10_vdrop0", {7'd0, valid0}, 8'd0);
        chk("r10_hold0", rdata0, 8'h5A);

        // Back-to-back reads at the array boundaries.
        req0(1'b1, 1'b1, 8'h00, 8'h01, 1'b0);
        tick();
        req0(1'b1, 1'b1, 8'hFF, 8'hFE, 1'b0);
        tick();
        req0(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("b2b_v0", {7'd0, valid0}, 8'd1);
        chk("b2b_d0", rdata0, 8'h01);
        req0(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
        tick();
        chk("b2b_v1", {7'd0, valid0}, 8'd1);
        chk("b2b_d1", rdata0, 8'hFE);
        req0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("b2b_vdrop", {7'd0, valid0}, 8'd0);
        chk("b2b_hold", rdata0, 8'hFE);

        // Parity: injected error is flagged only when the feature is built in.
        req0(1'b1, 1'b1, 8'h30, 8'h03, 1'b1);
        tick();
        req0(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
        tick();
        chk("par_inj_rdata", rdata0, 8'h03);
        chk("par_inj_valid", {7'd0, valid0}, 8'd1);
        chk("par_inj_err", {7'd0, perr0}, {7'd0, exp_perr});
        req0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("par_err_qual", {7'd0, perr0}, 8'd0);
        req0(1'b1, 1'b1, 8'h30, 8'h03, 1'b0);
        tick();
        req0(1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
        tick();
        chk("par_ok_rdata", rdata0, 8'h03);
        chk("par_ok_err", {7'd0, perr0}, 8'd0);
        req0(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // WAIT_STATES=2: writes issued while idle are accepted immediately.
        req2(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0);
        tick();
        chk("w2_stall", {7'd0, stall2}, 8'd0);
        req2(1'b1, 1'b1, 8'h40, 8'h33, 1'b0);
        tick();

        // Read with requests presented during the stall; only the one held past the stall commits.
        req2(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        tick();
        chk("s_stall1", {7'd0, stall2}, 8'd1);
        chk("s_nv1", {7'd0, valid2}, 8'd0);
        req2(1'b1, 1'b1, 8'h40, 8'hAA, 1'b0);
        tick();
        chk("s_stall2", {7'd0, stall2}, 8'd1);
        chk("s_nv2", {7'd0, valid2}, 8'd0);
        req2(1'b1, 1'b1, 8'h20, 8'h11, 1'b0);
        tick();
        chk("s_valid", {7'd0, valid2}, 8'd1);
        chk("s_rdata", rdata2, 8'h5A);
        chk("s_nostall", {7'd0, stall2}, 8'd0);
        tick();
        chk("s_wr_vdrop", {7'd0, valid2}, 8'd0);
        chk("s_wr_nostall", {7'd0, stall2}, 8'd0);
        req2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        read2("r20", 8'h20, 8'h11);
        read2("r40", 8'h40, 8'h33);

        // Reset during the first wait cycle drops the response.
        req2(1'b1, 1'b0, 8'h10, 8'h00, 1'b0);
        tick();
        req2(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        chk("mr_stall_pre", {7'd0, stall2}, 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("mr_rdata", rdata2, 8'h00);
        chk("mr_stall", {7'd0, stall2}, 8'd0);
        chk("mr_valid", {7'd0, valid2}, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_novalid", {7'd0, valid2}, 8'd0);
        end
        chk("mr_rdata_after", rdata2, 8'h00);
        read2("mr_r10", 8'h10, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
